// File: rtl/output_module.sv
// rtl/output_module.sv - 16-bit result FIFO presenting 32-bit words over STB/BUSY
// Optional packing of two entries per word: OUTPUT_MODULE_PACK_EN
module output_module #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   output_x,
    input  logic          op_output_STB,
    output logic          output_module_BUSY,
    input  logic          flush,
    output logic [31:0]   result,
    output logic          result_STB,
    input  logic          result_BUSY,
    output logic [CW-1:0] fill_level
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;

    logic          push, pop;
    logic [PW-1:0] pop_step;
    logic [15:0]   head0, head1;

    assign head0 = mem_q[rd_ptr_q];
    assign head1 = mem_q[rd_ptr_q + PW'(1)];

    assign output_module_BUSY = (state_q == FULL);
    assign fill_level         = count_q;

`ifdef OUTPUT_MODULE_PACK_EN
    always_comb begin
        result     = 32'h0;
        result_STB = 1'b0;
        pop_step   = PW'(1);
        if (count_q >= CW'(2)) begin
            result     = {head1, head0};
            result_STB = 1'b1;
            pop_step   = PW'(2);
        end else if (count_q == CW'(1)) begin
            result     = {16'h0, head0};
            result_STB = flush;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = flush;

    always_comb begin
        pop_step   = PW'(1);
        result_STB = (state_q != IDLE);
        result     = (state_q != IDLE) ? {16'h0, head0} : 32'h0;
    end
`endif

    // A pop from full never frees a slot for a push on the same edge.
    assign push = op_output_STB && !output_module_BUSY;
    assign pop  = result_STB && !result_BUSY;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + pop_step : rd_ptr_q;
        count_d  = count_q + CW'(push) - (pop ? CW'(pop_step) : CW'(0));
        if (pop && pop_step == PW'(0))
            count_d = count_q + CW'(push) - CW'(DEPTH);
        if (count_d == CW'(0))
            state_d = IDLE;
        else if (count_d == CW'(DEPTH))
            state_d = FULL;
        else
            state_d = FILL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= output_x;
    end

endmodule

// File: tb/tb_output_module.sv
// tb/tb_output_module.sv - directed and scoreboard bench for output_module
module tb_output_module;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] output_x = 16'h0;
    logic        op_output_STB = 1'b0;
    logic        output_module_BUSY;
    logic        flush = 1'b0;
    logic [31:0] result;
    logic        result_STB;
    logic        result_BUSY = 1'b1;
    logic [2:0]  fill_level;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] sb_q[$];

    output_module #(.DEPTH(4), .CW(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .output_x          (output_x),
        .op_output_STB     (op_output_STB),
        .output_module_BUSY(output_module_BUSY),
        .flush             (flush),
        .result            (result),
        .result_STB        (result_STB),
        .result_BUSY       (result_BUSY),
        .fill_level        (fill_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [15:0] v);
        output_x      = v;
        op_output_STB = 1'b1;
        tick();
        op_output_STB = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    initial begin
        #12 rst = 1'b0;
        tick();
        check("reset_fill", 32'(fill_level), 32'd0);
        check("reset_stb", 32'(result_STB), 32'd0);
        check("reset_busy", 32'(output_module_BUSY), 32'd0);

        // Mid-cycle asynchronous reset with three entries buffered.
        result_BUSY = 1'b1;
        push1(16'h0011);
        push1(16'h0022);
        push1(16'h0033);
        check("pre_reset_fill", 32'(fill_level), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_fill", 32'(fill_level), 32'd0);
        check("async_rst_stb", 32'(result_STB), 32'd0);
        check("async_rst_result", result, 32'h0);
        check("async_rst_busy", 32'(output_module_BUSY), 32'd0);
        #1 rst = 1'b0;
        tick();

`ifndef OUTPUT_MODULE_PACK_EN
        push1(16'h3F80);
        check("post_rst_result", result, 32'h0000_3F80);
        check("post_rst_stb", 32'(result_STB), 32'd1);
        do_reset();

        // Fill to full with downstream stalled.
        result_BUSY = 1'b1;
        for (int i = 1; i <= 4; i++) push1(16'(i));
        check("full_busy", 32'(output_module_BUSY), 32'd1);
        check("full_fill", 32'(fill_level), 32'd4);
        push1(16'h0005);
        check("full_reject_fill", 32'(fill_level), 32'd4);
        check("full_head", result, 32'h0000_0001);

        // Drain in order, one word per cycle.
        result_BUSY = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("drain_word", result, 32'(i));
            check("drain_stb", 32'(result_STB), 32'd1);
            tick();
            if (i == 1) check("drain_busy_drop", 32'(output_module_BUSY), 32'd0);
        end
        check("drain_empty_stb", 32'(result_STB), 32'd0);
        check("drain_empty_result", result, 32'h0);
        check("drain_empty_fill", 32'(fill_level), 32'd0);

        // Simultaneous push/pop at count 2 across pointer wrap.
        result_BUSY = 1'b1;
        push1(16'hA000);
        push1(16'hA001);
        result_BUSY   = 1'b0;
        op_output_STB = 1'b1;
        for (int i = 0; i < 10; i++) begin
            output_x = 16'hA002 + 16'(i);
            #1;
            check("pp_head", result, {16'h0, 16'hA000 + 16'(i)});
            tick();
            check("pp_fill", 32'(fill_level), 32'd2);
        end
        op_output_STB = 1'b0;
        result_BUSY   = 1'b1;
        do_reset();

        // Random handshake against a queue scoreboard.
        sb_q.delete();
        for (int c = 0; c < 1000; c++) begin
            op_output_STB = 1'($urandom_range(0, 1));
            output_x      = 16'($urandom);
            result_BUSY   = 1'($urandom_range(0, 1));
            #1;
            if (output_module_BUSY !== (sb_q.size() == 4)) check("rnd_busy", 32'(output_module_BUSY), 32'(sb_q.size() == 4));
            if (fill_level !== 3'(sb_q.size())) check("rnd_fill", 32'(fill_level), 32'(sb_q.size()));
            if (sb_q.size() > 0) begin
                if (result !== {16'h0, sb_q[0]}) check("rnd_data", result, {16'h0, sb_q[0]});
                if (!result_BUSY) void'(sb_q.pop_front());
            end else if (result_STB !== 1'b0) begin
                check("rnd_empty_stb", 32'(result_STB), 32'd0);
            end
            if (op_output_STB && fill_level != 3'd4) sb_q.push_back(output_x);
            tick();
        end
        op_output_STB = 1'b0;
        result_BUSY   = 1'b0;
        for (int c = 0; c < 8 && sb_q.size() > 0; c++) begin
            check("rnd_tail", result, {16'h0, sb_q[0]});
            void'(sb_q.pop_front());
            tick();
        end
        check("rnd_final_fill", 32'(fill_level), 32'd0);
        check("rnd_final_stb", 32'(result_STB), 32'd0);
`else
        // Pack mode: two entries per word, older in the low half.
        result_BUSY = 1'b1;
        push1(16'h3F80);
        push1(16'h0000);
        check("pack_result", result, 32'h0000_3F80);
        check("pack_stb", 32'(result_STB), 32'd1);
        push1(16'h5555);
        push1(16'h6666);
        check("pack_full", 32'(output_module_BUSY), 32'd1);
        result_BUSY = 1'b0;
        tick();
        check("pack_pop2_fill", 32'(fill_level), 32'd2);
        check("pack_second", result, 32'h6666_5555);
        tick();
        check("pack_drained", 32'(fill_level), 32'd0);
        result_BUSY = 1'b1;
        push1(16'h1234);
        result_BUSY = 1'b0;
        #1;
        check("lone_stb", 32'(result_STB), 32'd0);
        tick();
        check("lone_held", 32'(fill_level), 32'd1);
        flush = 1'b1;
        #1;
        check("flush_stb", 32'(result_STB), 32'd1);
        check("flush_result", result, 32'h0000_1234);
        tick();
        flush = 1'b0;
        check("flush_pop1", 32'(fill_level), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
